cmd_txn_tracker: RTL and testbench
==================================

Name: cmd_txn_tracker

Overview:
- Synthesizable command-protocol tracker/checker for the RST/INIT/ADD/SUB/MULT/DIV/REM/HLT command interface.
- Tracks up to DEPTH outstanding tagged commands from issue handshake to done, in either in-order or out-of-order completion mode.
- Flags protocol violations: overflow, duplicate/unknown tags, opcode mismatch, completion order, latency timeout, HLT while busy, illegal command sequencing.
- Sits passively beside the command master and the execution unit; it drives no handshake signals.

Parameters:
DEPTH, 8, maximum outstanding tracked commands (>=2)
TAG_W, 3, command tag width
LAT_MAX, 7, cycles after issue before an uncompleted entry times out (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ooo_mode  in  1  1=out-of-order completion allowed, 0=in-order
clr_err  in  1  clears err_sticky
cmd_vld  in  1  command valid
cmd_rdy  in  1  command ready; issue = cmd_vld&cmd_rdy
cmd_op  in  3  opcode: RST=0 INIT=1 ADD=2 SUB=3 MULT=4 DIV=5 REM=6 HLT=7
cmd_tag  in  TAG_W  command tag
done_vld  in  1  completion strobe
done_op  in  3  completed opcode
done_tag  in  TAG_W  completed tag
outstanding  out  clog2(DEPTH+1)  valid entry count
full  out  1  outstanding==DEPTH
empty  out  1  outstanding==0
err_pulse  out  8  one-cycle error strobes
err_sticky  out  8  accumulated errors

Behaviour:
- Error bits: 0 overflow, 1 dup_tag, 2 unknown_done, 3 op_mismatch, 4 order, 5 timeout, 6 hlt_busy, 7 seq.
- Reset: table cleared, outstanding=0, full=0, empty=1, err_pulse=0, err_sticky=0, phase=IDLE, issue_seq=retire_seq=0, latched mode=ooo_mode.
- All outputs are registered. An error pulses in the cycle after the offending handshake.
- Phase FSM:
  - IDLE: INIT -> RUN. Any other op -> err seq, ignored.
  - RUN: ADD..REM tracked. INIT legal, untracked. HLT -> HALTED. RST -> err seq, ignored.
  - HALTED: RST -> IDLE. Any other op -> err seq, ignored.
- Only ADD..REM allocate entries. Phase never clears the table.
- HLT in RUN with outstanding!=0: err hlt_busy, still moves to HALTED. Existing entries keep retiring.
- Entry fields: valid, tag, op, seq (clog2(DEPTH)+1 bits), age (saturating at LAT_MAX).
- Issue allocates the lowest free index, seq=issue_seq, age=0; issue_seq increments.
- Done processing (evaluated against the pre-cycle table):
  - No valid tag match -> err unknown_done.
  - Match: retired (valid=0). If done_op!=entry op, also err op_mismatch; the entry still retires.
  - In-order mode, matched entry seq!=retire_seq -> err order, entry NOT retired. Otherwise retire and retire_seq increments.
  - Out-of-order mode ignores seq.
- Issue checks:
  - Tag matching a valid entry not retiring this cycle -> err dup_tag, dropped.
  - No free slot after same-cycle retire -> err overflow, dropped.
  - A same-cycle retire frees a slot usable by that cycle's issue.
  - Same-cycle issue and done of an identical new tag: done -> unknown_done, issue allocates.
- Age: each valid entry's age increments per cycle. When age reaches LAT_MAX, err timeout pulses once for that entry; the entry stays valid. Multiple same-cycle timeouts OR into one pulse.
- Mode: ooo_mode is latched only while the table is empty (retire_seq:=issue_seq on latch). Changes while non-empty are deferred until empty.
- err_sticky |= err_pulse every cycle. clr_err zeroes it; a coincident pulse still sets its bit.
- rst mid-operation discards all entries in the same cycle; no errors are reported for them.

Test Plan:
- rst, INIT, ADD tag1, SUB tag2, done SUB/2 then ADD/1 with ooo_mode=1 -> no errors; outstanding 0,1,2,1,0; empty=1 at end.
- Same sequence with ooo_mode=0 -> done SUB/2 gives err_pulse[4]; entry kept. Done ADD/1 then SUB/2 -> clean retires, outstanding 0.
- Issue 9 ADDs, tags 0..7 then 0, no done, DEPTH=8 -> full=1 after 8th. 9th -> err_pulse[1] (dup) only. Next cycle done tag0 plus issue tag0 -> accepted, full stays 1.
- ADD tag3 with no done for 7 cycles -> err_pulse[5] single pulse 8 cycles after issue; done DIV/3 -> err_pulse[3], outstanding 0.
- After rst: ADD -> err_pulse[7]. INIT, MULT tag5, HLT -> err_pulse[6], phase HALTED. INIT -> err_pulse[7]. RST, INIT, REM -> clean.
- done tag6 never issued -> err_pulse[2]; err_sticky=0x04 persists until clr_err, then 0x00.

Source files
------------

// File: rtl/cmd_txn_tracker.sv
// Passive tracker for tagged commands, from the issue handshake until done, with protocol checks.
// All outputs are registered, so each error pulses one cycle after its handshake. Drives no handshakes.
module cmd_txn_tracker #(
   parameter int DEPTH   = 8,
   parameter int TAG_W   = 3,
   parameter int LAT_MAX = 7
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ooo_mode,
   input  logic                       clr_err,
   input  logic                       cmd_vld,
   input  logic                       cmd_rdy,
   input  logic [2:0]                 cmd_op,
   input  logic [TAG_W-1:0]           cmd_tag,
   input  logic                       done_vld,
   input  logic [2:0]                 done_op,
   input  logic [TAG_W-1:0]           done_tag,
   output logic [$clog2(DEPTH+1)-1:0] outstanding,
   output logic                       full,
   output logic                       empty,
   output logic [7:0]                 err_pulse,
   output logic [7:0]                 err_sticky
);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int SEQ_W = IDX_W + 1;
   localparam int AGE_W = $clog2(LAT_MAX+1);
   localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(LAT_MAX);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   localparam logic [2:0] OP_RST  = 3'd0;
   localparam logic [2:0] OP_INIT = 3'd1;
   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_REM  = 3'd6;
   localparam logic [2:0] OP_HLT  = 3'd7;

   typedef enum logic [1:0] {
      PH_IDLE   = 2'd0,
      PH_RUN    = 2'd1,
      PH_HALTED = 2'd2
   } phase_t;

   phase_t phase_q, phase_d;

   logic [DEPTH-1:0] ent_vld;
   logic [DEPTH-1:0] ent_tmo;
   logic [TAG_W-1:0] ent_tag [DEPTH];
   logic [2:0]       ent_op  [DEPTH];
   logic [SEQ_W-1:0] ent_seq [DEPTH];
   logic [AGE_W-1:0] ent_age [DEPTH];

   logic             mode_q;
   logic [SEQ_W-1:0] issue_seq_q;
   logic [SEQ_W-1:0] retire_seq_q;

   logic             issue;
   logic [DEPTH-1:0] done_hit;
   logic [IDX_W-1:0] hit_idx;
   logic             hit_any;
   logic             order_ok;
   logic             retire;
   logic [DEPTH-1:0] retire_vec;
   logic [DEPTH-1:0] dup_hit;
   logic             free_any;
   logic [IDX_W-1:0] alloc_idx;
   logic [DEPTH-1:0] tmo_hit;
   logic             track;
   logic             dup;
   logic             alloc;
   logic             seq_err;
   logic             hlt_err;
   logic [7:0]       err_d;
   logic [CNT_W-1:0] cnt_d;

   assign issue = cmd_vld & cmd_rdy;

   // Tags are unique among valid entries, so at most one entry can match a done.
   always_comb begin
      done_hit = '0;
      hit_idx  = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (ent_vld[i] && ent_tag[i] == done_tag) begin
            done_hit[i] = 1'b1;
            hit_idx     = IDX_W'(i);
         end
      end
   end

   assign hit_any    = |done_hit;
   assign order_ok   = mode_q || (ent_seq[hit_idx] == retire_seq_q);
   assign retire     = done_vld && hit_any && order_ok;
   assign retire_vec = done_hit & {DEPTH{retire}};

   // A slot retiring this cycle counts as free, and its tag no longer counts as a duplicate.
   always_comb begin
      dup_hit   = '0;
      free_any  = 1'b0;
      alloc_idx = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (ent_vld[i] && !retire_vec[i] && ent_tag[i] == cmd_tag)
            dup_hit[i] = 1'b1;
         if (!ent_vld[i] || retire_vec[i]) begin
            free_any  = 1'b1;
            alloc_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      tmo_hit = '0;
      for (int i = 0; i < DEPTH; i++)
         tmo_hit[i] = ent_vld[i] && (ent_age[i] == AGE_MAX) && !ent_tmo[i];
   end

   always_comb begin
      phase_d = phase_q;
      track   = 1'b0;
      seq_err = 1'b0;
      hlt_err = 1'b0;
      case (phase_q)
         PH_IDLE: begin
            if (issue) begin
               if (cmd_op == OP_INIT) phase_d = PH_RUN;
               else                   seq_err = 1'b1;
            end
         end
         PH_RUN: begin
            if (issue) begin
               if (cmd_op == OP_RST) begin
                  seq_err = 1'b1;
               end else if (cmd_op == OP_HLT) begin
                  phase_d = PH_HALTED;
                  hlt_err = (outstanding != '0);
               end else if (cmd_op >= OP_ADD && cmd_op <= OP_REM) begin
                  track = 1'b1;
               end
            end
         end
         PH_HALTED: begin
            if (issue) begin
               if (cmd_op == OP_RST) phase_d = PH_IDLE;
               else                  seq_err = 1'b1;
            end
         end
         default: phase_d = PH_IDLE;
      endcase
   end

   assign dup   = track && (|dup_hit);
   assign alloc = track && !dup && free_any;

   assign err_d[0] = track && !dup && !free_any;
   assign err_d[1] = dup;
   assign err_d[2] = done_vld && !hit_any;
   assign err_d[3] = done_vld && hit_any && (ent_op[hit_idx] != done_op);
   assign err_d[4] = done_vld && hit_any && !order_ok;
   assign err_d[5] = |tmo_hit;
   assign err_d[6] = hlt_err;
   assign err_d[7] = seq_err;

   assign cnt_d = outstanding + CNT_W'(alloc) - CNT_W'(retire);

   always_ff @(posedge clk) begin
      if (rst) phase_q <= PH_IDLE;
      else     phase_q <= phase_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ent_vld      <= '0;
         ent_tmo      <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_tag[i] <= '0;
            ent_op[i]  <= '0;
            ent_seq[i] <= '0;
            ent_age[i] <= '0;
         end
         mode_q       <= ooo_mode;
         issue_seq_q  <= '0;
         retire_seq_q <= '0;
         outstanding  <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         err_pulse    <= '0;
         err_sticky   <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (retire_vec[i]) begin
               ent_vld[i] <= 1'b0;
            end else if (ent_vld[i]) begin
               if (ent_age[i] != AGE_MAX) ent_age[i] <= ent_age[i] + AGE_W'(1);
               if (tmo_hit[i])            ent_tmo[i] <= 1'b1;
            end
         end
         // Allocation comes last so it wins over a retire of the same slot.
         if (alloc) begin
            ent_vld[alloc_idx] <= 1'b1;
            ent_tmo[alloc_idx] <= 1'b0;
            ent_tag[alloc_idx] <= cmd_tag;
            ent_op[alloc_idx]  <= cmd_op;
            ent_seq[alloc_idx] <= issue_seq_q;
            ent_age[alloc_idx] <= '0;
         end
         issue_seq_q <= issue_seq_q + SEQ_W'(alloc);

         // The mode can only change on an empty table, which also resyncs the in-order pointer.
         if (outstanding == '0) begin
            mode_q       <= ooo_mode;
            retire_seq_q <= issue_seq_q;
         end else if (retire && !mode_q) begin
            retire_seq_q <= retire_seq_q + SEQ_W'(1);
         end

         outstanding <= cnt_d;
         full        <= (cnt_d == CNT_FULL);
         empty       <= (cnt_d == '0);
         err_pulse   <= err_d;
         err_sticky  <= (clr_err ? 8'h00 : err_sticky) | err_pulse;
      end
   end

endmodule

// File: tb/tb_cmd_txn_tracker.sv
// Randomized and directed bench for cmd_txn_tracker with a queue-based transaction model and scoreboard.
module tb_cmd_txn_tracker;
   localparam int DEPTH   = 8;
   localparam int TAG_W   = 3;
   localparam int LAT_MAX = 7;
   localparam int CNT_W   = $clog2(DEPTH+1);

   localparam int RST = 0, INIT = 1, ADD = 2, SUB = 3, MULT = 4, DIV = 5, REM = 6, HLT = 7;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             ooo_mode = 1'b0;
   logic             clr_err = 1'b0;
   logic             cmd_vld = 1'b0;
   logic             cmd_rdy = 1'b0;
   logic [2:0]       cmd_op = '0;
   logic [TAG_W-1:0] cmd_tag = '0;
   logic             done_vld = 1'b0;
   logic [2:0]       done_op = '0;
   logic [TAG_W-1:0] done_tag = '0;
   logic [CNT_W-1:0] outstanding;
   logic             full;
   logic             empty;
   logic [7:0]       err_pulse;
   logic [7:0]       err_sticky;

   always #5 clk = ~clk;

   cmd_txn_tracker #(.DEPTH(DEPTH), .TAG_W(TAG_W), .LAT_MAX(LAT_MAX)) dut (
      .clk(clk), .rst(rst), .ooo_mode(ooo_mode), .clr_err(clr_err),
      .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
      .done_vld(done_vld), .done_op(done_op), .done_tag(done_tag),
      .outstanding(outstanding), .full(full), .empty(empty),
      .err_pulse(err_pulse), .err_sticky(err_sticky)
   );

   typedef struct {
      logic [7:0] pulse;
      logic [7:0] sticky;
      int         cnt;
   } exp_t;

   typedef struct {
      int tag;
      int op;
      int t;
   } txn_t;

   exp_t       exp_q[$];
   txn_t       tbl[$];   // outstanding commands, oldest first
   int         m_phase;  // 0 idle, 1 run, 2 halted
   bit         m_ooo;
   logic [7:0] m_pulse;
   logic [7:0] m_sticky;
   int         cyc = 0;
   int         tests = 0;
   int         fails = 0;
   bit         mode = 1'b1;

   task automatic chk(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, req);
      end
   endtask

   // One clock of stimulus; the model predicts what the outputs will show after the next edge.
   task automatic step(input bit r, input bit ooo, input bit clr, input bit cv, input bit cr,
                       input int cop, input int ctag, input bit dv, input int dop, input int dtag);
      exp_t       x;
      txn_t       n;
      logic [7:0] e;
      int         hit;
      int         pre_n;
      bit         ret;
      bit         dup;
      bit         add;
      @(negedge clk);
      rst = r; ooo_mode = ooo; clr_err = clr;
      cmd_vld = cv; cmd_rdy = cr; cmd_op = 3'(cop); cmd_tag = TAG_W'(ctag);
      done_vld = dv; done_op = 3'(dop); done_tag = TAG_W'(dtag);
      cyc++;
      if (r) begin
         tbl.delete();
         m_phase = 0; m_ooo = ooo; m_pulse = '0; m_sticky = '0;
      end else begin
         e = '0; pre_n = tbl.size(); hit = -1; ret = 0; add = 0;
         foreach (tbl[i]) if (tbl[i].t + LAT_MAX + 1 == cyc) e[5] = 1'b1;
         if (dv) begin
            foreach (tbl[i]) if (tbl[i].tag == dtag) hit = i;
            if (hit < 0) e[2] = 1'b1;
            else begin
               if (tbl[hit].op != dop) e[3] = 1'b1;
               if (!m_ooo && hit != 0) e[4] = 1'b1;
               else ret = 1;
            end
         end
         if (cv && cr) begin
            case (m_phase)
               0: if (cop == INIT) m_phase = 1; else e[7] = 1'b1;
               1: begin
                  if (cop == RST) e[7] = 1'b1;
                  else if (cop == HLT) begin
                     m_phase = 2;
                     if (pre_n != 0) e[6] = 1'b1;
                  end else if (cop >= ADD && cop <= REM) begin
                     dup = 0;
                     foreach (tbl[i]) if (tbl[i].tag == ctag && !(ret && i == hit)) dup = 1;
                     if (dup) e[1] = 1'b1;
                     else if (pre_n - int'(ret) >= DEPTH) e[0] = 1'b1;
                     else add = 1;
                  end
               end
               default: if (cop == RST) m_phase = 0; else e[7] = 1'b1;
            endcase
         end
         if (ret) tbl.delete(hit);
         if (add) begin
            n.tag = ctag; n.op = cop; n.t = cyc;
            tbl.push_back(n);
         end
         if (pre_n == 0) m_ooo = ooo;
         m_sticky = (clr ? 8'h00 : m_sticky) | m_pulse;
         m_pulse  = e;
      end
      x.pulse = m_pulse; x.sticky = m_sticky; x.cnt = tbl.size();
      exp_q.push_back(x);
   endtask

   task automatic do_rst();                     step(1, mode, 0, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic cmd(input int op, input int tag); step(0, mode, 0, 1, 1, op, tag, 0, 0, 0); endtask
   task automatic dn(input int op, input int tag);  step(0, mode, 0, 0, 0, 0, 0, 1, op, tag); endtask
   task automatic idle(input int k);
      for (int i = 0; i < k; i++) step(0, mode, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: every cycle with a pending prediction, compare it against the registered outputs.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("err_pulse", int'(err_pulse), int'(x.pulse));
            chk("err_sticky", int'(err_sticky), int'(x.sticky));
            chk("outstanding", int'(outstanding), x.cnt);
            chk("full", int'(full), int'(x.cnt == DEPTH));
            chk("empty", int'(empty), int'(x.cnt == 0));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cop, ctag, dop, dtag, k;
      bit cv, dv;
      // Out-of-order completion of two commands.
      mode = 1;
      do_rst(); cmd(INIT, 0); cmd(ADD, 1); cmd(SUB, 2); dn(SUB, 2); dn(ADD, 1); idle(2);
      // Same traffic in order: the early SUB done is an order error and stays outstanding.
      mode = 0;
      do_rst(); cmd(INIT, 0); cmd(ADD, 1); cmd(SUB, 2); dn(SUB, 2); dn(ADD, 1); dn(SUB, 2); idle(2);
      // Fill to DEPTH, duplicate tag, then retire and reissue a tag in one cycle.
      do_rst(); cmd(INIT, 0);
      for (int t = 0; t < 8; t++) cmd(ADD, t);
      cmd(ADD, 0);
      step(0, mode, 0, 1, 1, ADD, 0, 1, ADD, 0);
      idle(2);
      // Timeout, then a mismatched-opcode completion.
      do_rst(); cmd(INIT, 0); cmd(ADD, 3); idle(9); dn(DIV, 3); idle(2);
      // Phase sequencing.
      do_rst(); cmd(ADD, 1); cmd(INIT, 0); cmd(MULT, 5); cmd(HLT, 0); cmd(INIT, 0);
      cmd(RST, 0); cmd(INIT, 0); cmd(REM, 2); idle(2);
      // Unknown done, sticky hold and clear.
      do_rst(); cmd(INIT, 0); dn(ADD, 6); idle(3);
      step(0, mode, 1, 0, 0, 0, 0, 0, 0, 0); idle(2);

      // Randomized traffic.
      do_rst(); cmd(INIT, 0);
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(99) < 3) mode = ~mode;
         k = $urandom_range(99);
         if (k < 70)      cop = $urandom_range(REM, ADD);
         else if (k < 80) cop = INIT;
         else if (k < 90) cop = RST;
         else             cop = HLT;
         ctag = $urandom_range(7);
         cv   = ($urandom_range(99) < 55);
         dv   = ($urandom_range(99) < 45);
         if (tbl.size() > 0 && $urandom_range(99) < 75) begin
            k    = $urandom_range(tbl.size() - 1);
            dtag = tbl[k].tag;
            dop  = ($urandom_range(99) < 85) ? tbl[k].op : $urandom_range(7);
         end else begin
            dtag = $urandom_range(7);
            dop  = $urandom_range(7);
         end
         step(($urandom_range(199) == 0), mode, ($urandom_range(99) < 3),
              cv, ($urandom_range(99) < 80), cop, ctag, dv, dop, dtag);
      end
      idle(2);

      for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
      @(posedge clk); #2;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
